// File: rtl/pipeline_control_unit.sv
// -----------------------------------------------------------------------------
// pipeline_control_unit
//
// Central stall/flush sequencer for the 5-stage RV32I pipeline. It merges the
// ID-stage hazard stall, the ID-resolved branch redirect, the instruction and
// data memory ready handshakes and the ecall/ebreak halt request into
// per-stage write-enables and bubble-inserts for the pipeline registers. It
// also runs the halt-drain FSM (RUN -> DRAIN -> HALTED -> RUN) and keeps two
// saturating performance counters.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   hazard_stall   load-use / branch-operand stall request (ID)
//   branch_taken   branch/jump in ID resolved taken
//   halt_req       ecall/ebreak decoded in ID
//   resume         leave HALTED
//   imem_ready     fetch data valid this cycle
//   dmem_req       MEM stage holds a load/store
//   dmem_ready     data memory completes the MEM access this cycle
//   cnt_clr        synchronous clear of both counters
//   pc_en          PC write-enable
//   if_id_en       IF/ID write-enable
//   if_id_flush    load NOP into IF/ID
//   id_ex_en       ID/EX write-enable
//   id_ex_flush    load bubble into ID/EX
//   ex_mem_en      EX/MEM write-enable
//   mem_wb_flush   load bubble into MEM/WB (MEM/WB writes otherwise)
//   halted         registered, high while in HALTED
//   stall_cycles   cycles with pc_en=0 outside HALTED (saturating)
//   redirect_count accepted taken-branch redirects (saturating)
// -----------------------------------------------------------------------------
module pipeline_control_unit #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hazard_stall,
  input  logic             branch_taken,
  input  logic             halt_req,
  input  logic             resume,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             cnt_clr,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] redirect_count
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  // Drain counter wide enough to hold DRAIN_CYCLES itself.
  localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] redirect_count_q, redirect_count_d;

  logic             mstall;
  logic             redirect_inc;
  logic             stall_inc;

  // A data-memory wait freezes everything up to and including EX/MEM and
  // bubbles MEM/WB so the incomplete access is not retired twice.
  assign mstall = dmem_req & ~dmem_ready;

  // ---------------------------------------------------------------------------
  // Stage control and next-state decode
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_flush = 1'b0;
    state_d      = state_q;
    drain_d      = drain_q;
    redirect_inc = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (mstall) begin
          // Held instructions re-present their requests next cycle.
          mem_wb_flush = 1'b1;
        end else if (hazard_stall) begin
          id_ex_flush = 1'b1;
          ex_mem_en   = 1'b1;
        end else if (halt_req) begin
          // The ecall/ebreak moves on into EX; nothing younger follows it.
          if_id_flush = 1'b1;
          id_ex_en    = 1'b1;
          ex_mem_en   = 1'b1;
          state_d     = ST_DRAIN;
          drain_d     = DW'(DRAIN_CYCLES);
        end else if (branch_taken) begin
          // Redirect loads the target even when the current fetch is not ready.
          pc_en        = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_en     = 1'b1;
          ex_mem_en    = 1'b1;
          redirect_inc = 1'b1;
        end else if (!imem_ready) begin
          if_id_flush = 1'b1;
          id_ex_en    = 1'b1;
          ex_mem_en   = 1'b1;
        end else begin
          pc_en     = 1'b1;
          if_id_en  = 1'b1;
          id_ex_en  = 1'b1;
          ex_mem_en = 1'b1;
        end
      end

      ST_DRAIN: begin
        // Front end stays empty while the halting instruction walks to WB.
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        if (mstall) begin
          mem_wb_flush = 1'b1;
        end else begin
          ex_mem_en = 1'b1;
          if (drain_q <= DW'(1)) begin
            state_d = ST_HALTED;
            drain_d = '0;
          end else begin
            drain_d = drain_q - DW'(1);
          end
        end
      end

      ST_HALTED: begin
        if (resume) begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_RUN;
        drain_d = '0;
      end
    endcase

    // Asynchronous reset must silence the pipeline immediately, not at the
    // next edge.
    if (!rst_n) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_en     = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b0;
      redirect_inc = 1'b0;
    end
  end

  // halted is registered from the next state so it rises the cycle after the
  // last drain cycle and falls the cycle after resume.
  assign halted_d = (state_d == ST_HALTED);

  // ---------------------------------------------------------------------------
  // Performance counters (saturating, clear wins over increment)
  // ---------------------------------------------------------------------------
  assign stall_inc = (state_q != ST_HALTED) & ~pc_en;

  always_comb begin
    stall_cycles_d   = stall_cycles_q;
    redirect_count_d = redirect_count_q;
    if (cnt_clr) begin
      stall_cycles_d   = '0;
      redirect_count_d = '0;
    end else begin
      if (stall_inc && (stall_cycles_q != CNT_MAX)) begin
        stall_cycles_d = stall_cycles_q + CNT_W'(1);
      end
      if (redirect_inc && (redirect_count_q != CNT_MAX)) begin
        redirect_count_d = redirect_count_q + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_RUN;
      drain_q          <= '0;
      halted_q         <= 1'b0;
      stall_cycles_q   <= '0;
      redirect_count_q <= '0;
    end else begin
      state_q          <= state_d;
      drain_q          <= drain_d;
      halted_q         <= halted_d;
      stall_cycles_q   <= stall_cycles_d;
      redirect_count_q <= redirect_count_d;
    end
  end

  assign halted         = halted_q;
  assign stall_cycles   = stall_cycles_q;
  assign redirect_count = redirect_count_q;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// -----------------------------------------------------------------------------
// Directed testbench for pipeline_control_unit. Counters are built 4 bits wide
// so saturation is reachable with a handful of stall cycles.
// Stage outputs are checked as a packed vector:
//   {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush}
// -----------------------------------------------------------------------------
module tb_pipeline_control_unit;

  localparam int CW = 4;

  localparam logic [6:0] O_ZERO   = 7'b0000000;
  localparam logic [6:0] O_NORM   = 7'b1101010;
  localparam logic [6:0] O_HAZ    = 7'b0000110;
  localparam logic [6:0] O_MSTALL = 7'b0000001;
  localparam logic [6:0] O_HALTA  = 7'b0011010;
  localparam logic [6:0] O_BRANCH = 7'b1011010;
  localparam logic [6:0] O_NOFET  = 7'b0011010;
  localparam logic [6:0] O_DRAIN  = 7'b0010110;
  localparam logic [6:0] O_DRMST  = 7'b0010101;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          hazard_stall, branch_taken, halt_req, resume;
  logic          imem_ready, dmem_req, dmem_ready, cnt_clr;
  logic          pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic          ex_mem_en, mem_wb_flush, halted;
  logic [CW-1:0] stall_cycles, redirect_count;
  logic [6:0]    outs;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  assign outs = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush};

  pipeline_control_unit #(.DRAIN_CYCLES(3), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .hazard_stall(hazard_stall), .branch_taken(branch_taken),
    .halt_req(halt_req), .resume(resume),
    .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .cnt_clr(cnt_clr),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
    .mem_wb_flush(mem_wb_flush), .halted(halted),
    .stall_cycles(stall_cycles), .redirect_count(redirect_count)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    hazard_stall = 1'b0; branch_taken = 1'b0; halt_req = 1'b0; resume = 1'b0;
    imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b0; cnt_clr = 1'b0;
  endtask

  // One idle cycle with cnt_clr so each scenario starts from zero counts.
  task automatic clear_counters();
    idle_inputs();
    cnt_clr = 1'b1;
    next_cycle();
    cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    vectors++;
    if (outs !== O_ZERO || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: outs=%b halted=%b, required outs=%b halted=0", outs, halted, O_ZERO);
    end
    vectors++;
    if (stall_cycles !== 4'd0 || redirect_count !== 4'd0) begin
      errors++;
      $display("FAIL reset_counters: stall=%0d redirect=%0d, required 0/0", stall_cycles, redirect_count);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #3;
    vectors++;
    if (outs !== O_NORM) begin
      errors++;
      $display("FAIL idle_run: outs=%b, required %b", outs, O_NORM);
    end
    next_cycle();
    vectors++;
    if (stall_cycles !== 4'd0 || redirect_count !== 4'd0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL idle_state: stall=%0d redirect=%0d halted=%b, required 0/0/0", stall_cycles, redirect_count, halted);
    end
    $display("reset/idle: outs=%b stall=%0d redirect=%0d halted=%b", outs, stall_cycles, redirect_count, halted);
  endtask

  task automatic test_hazard();
    hazard_stall = 1'b1;
    #3;
    vectors++;
    if (outs !== O_HAZ) begin
      errors++;
      $display("FAIL hazard_outputs: outs=%b, required %b", outs, O_HAZ);
    end
    next_cycle();
    hazard_stall = 1'b0;
    vectors++;
    if (stall_cycles !== 4'd1) begin
      errors++;
      $display("FAIL hazard_count: stall=%0d, required 1", stall_cycles);
    end
    $display("hazard: stall=%0d", stall_cycles);
  endtask

  task automatic test_mstall();
    clear_counters();
    dmem_req = 1'b1; dmem_ready = 1'b0; hazard_stall = 1'b1; branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #3;
      vectors++;
      if (outs !== O_MSTALL) begin
        errors++;
        $display("FAIL mstall_outputs[%0d]: outs=%b, required %b", i, outs, O_MSTALL);
      end
      next_cycle();
    end
    idle_inputs();
    vectors++;
    if (stall_cycles !== 4'd3 || redirect_count !== 4'd0) begin
      errors++;
      $display("FAIL mstall_counts: stall=%0d redirect=%0d, required 3/0", stall_cycles, redirect_count);
    end
    $display("mstall x3: stall=%0d redirect=%0d", stall_cycles, redirect_count);
  endtask

  task automatic test_branch();
    clear_counters();
    branch_taken = 1'b1; imem_ready = 1'b0;
    #3;
    vectors++;
    if (outs !== O_BRANCH) begin
      errors++;
      $display("FAIL branch_outputs: outs=%b, required %b", outs, O_BRANCH);
    end
    next_cycle();
    branch_taken = 1'b0;
    #3;
    vectors++;
    if (outs !== O_NOFET) begin
      errors++;
      $display("FAIL imem_wait_outputs: outs=%b, required %b", outs, O_NOFET);
    end
    vectors++;
    if (redirect_count !== 4'd1 || stall_cycles !== 4'd0) begin
      errors++;
      $display("FAIL branch_counts: redirect=%0d stall=%0d, required 1/0", redirect_count, stall_cycles);
    end
    next_cycle();
    imem_ready = 1'b1;
    vectors++;
    if (stall_cycles !== 4'd1) begin
      errors++;
      $display("FAIL imem_wait_count: stall=%0d, required 1", stall_cycles);
    end
    $display("branch: redirect=%0d stall=%0d", redirect_count, stall_cycles);
  endtask

  task automatic test_halt();
    logic [6:0] exp_drain [4];
    exp_drain[0] = O_DRAIN; exp_drain[1] = O_DRMST;
    exp_drain[2] = O_DRAIN; exp_drain[3] = O_DRAIN;
    clear_counters();
    // Acceptance cycle: halt beats the simultaneous branch.
    halt_req = 1'b1; branch_taken = 1'b1;
    #3;
    vectors++;
    if (outs !== O_HALTA) begin
      errors++;
      $display("FAIL halt_accept_outputs: outs=%b, required %b", outs, O_HALTA);
    end
    next_cycle();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin dmem_req = 1'b1; dmem_ready = 1'b0; end
      if (i == 2) begin hazard_stall = 1'b1; branch_taken = 1'b1; halt_req = 1'b1; end
      #3;
      vectors++;
      if (outs !== exp_drain[i] || halted !== 1'b0) begin
        errors++;
        $display("FAIL drain_cycle[%0d]: outs=%b halted=%b, required outs=%b halted=0", i, outs, halted, exp_drain[i]);
      end
      next_cycle();
      idle_inputs();
    end
    // Five edges after acceptance.
    vectors++;
    if (halted !== 1'b1 || outs !== O_ZERO) begin
      errors++;
      $display("FAIL halted_entry: halted=%b outs=%b, required 1/%b", halted, outs, O_ZERO);
    end
    vectors++;
    if (redirect_count !== 4'd0 || stall_cycles !== 4'd5) begin
      errors++;
      $display("FAIL halt_counts: redirect=%0d stall=%0d, required 0/5", redirect_count, stall_cycles);
    end
    repeat (2) next_cycle();
    vectors++;
    if (halted !== 1'b1 || stall_cycles !== 4'd5) begin
      errors++;
      $display("FAIL halted_hold: halted=%b stall=%0d, required 1/5", halted, stall_cycles);
    end
    resume = 1'b1;
    #3;
    vectors++;
    if (outs !== O_ZERO || halted !== 1'b1) begin
      errors++;
      $display("FAIL resume_cycle: outs=%b halted=%b, required %b/1", outs, halted, O_ZERO);
    end
    next_cycle();
    resume = 1'b0;
    #3;
    vectors++;
    if (halted !== 1'b0 || outs !== O_NORM) begin
      errors++;
      $display("FAIL resumed_run: halted=%b outs=%b, required 0/%b", halted, outs, O_NORM);
    end
    next_cycle();
    $display("halt/drain/resume: halted=%b stall=%0d", halted, stall_cycles);
  endtask

  task automatic test_saturation();
    clear_counters();
    hazard_stall = 1'b1;
    repeat (13) next_cycle();
    vectors++;
    if (stall_cycles !== 4'd13) begin
      errors++;
      $display("FAIL preset_count: stall=%0d, required 13", stall_cycles);
    end
    repeat (5) next_cycle();
    vectors++;
    if (stall_cycles !== 4'd15) begin
      errors++;
      $display("FAIL stall_saturate: stall=%0d, required 15", stall_cycles);
    end
    cnt_clr = 1'b1;
    next_cycle();
    cnt_clr = 1'b0;
    hazard_stall = 1'b0;
    vectors++;
    if (stall_cycles !== 4'd0) begin
      errors++;
      $display("FAIL clr_over_inc: stall=%0d, required 0", stall_cycles);
    end
    branch_taken = 1'b1;
    repeat (17) next_cycle();
    branch_taken = 1'b0;
    vectors++;
    if (redirect_count !== 4'd15) begin
      errors++;
      $display("FAIL redirect_saturate: redirect=%0d, required 15", redirect_count);
    end
    $display("saturation: stall=%0d redirect=%0d", stall_cycles, redirect_count);
  endtask

  task automatic test_reset_in_drain();
    halt_req = 1'b1;
    next_cycle();
    halt_req = 1'b0;
    #3;
    vectors++;
    if (outs !== O_DRAIN) begin
      errors++;
      $display("FAIL drain_before_reset: outs=%b, required %b", outs, O_DRAIN);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (outs !== O_ZERO || halted !== 1'b0 || stall_cycles !== 4'd0 || redirect_count !== 4'd0) begin
      errors++;
      $display("FAIL reset_in_drain: outs=%b halted=%b stall=%0d redirect=%0d, required %b/0/0/0",
               outs, halted, stall_cycles, redirect_count, O_ZERO);
    end
    next_cycle();
    rst_n = 1'b1;
    #3;
    vectors++;
    if (outs !== O_NORM) begin
      errors++;
      $display("FAIL run_after_reset: outs=%b, required %b", outs, O_NORM);
    end
    repeat (6) next_cycle();
    vectors++;
    if (halted !== 1'b0 || outs !== O_NORM) begin
      errors++;
      $display("FAIL no_late_halt: halted=%b outs=%b, required 0/%b", halted, outs, O_NORM);
    end
    $display("reset in drain: outs=%b halted=%b", outs, halted);
  endtask

  initial begin
    test_reset();
    test_hazard();
    test_mstall();
    test_branch();
    test_halt();
    test_saturation();
    test_reset_in_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
